// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: parity encodings,
// receive FSM states and a constant-foldable ceil(log2) helper.
package uart_pkg;

    // Parity selection values for the PARITY parameter
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Receive FSM states
    typedef enum logic [2:0] {
        ST_WAIT_INIT,
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// RX line conditioning: 2-flop synchroniser followed by a saturating
// up/down counter stepped once per oversample tick. The filtered line only
// flips when the counter reaches all-ones or zero, so short glitches vanish.
module uart_rx_filter
    import uart_pkg::*;
#(
    parameter int FILTER_BITS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic pin,
    output logic line
);

    localparam logic [FILTER_BITS-1:0] CNT_MAX = '1;

    logic                   sync_1;
    logic                   sync_2;
    logic [FILTER_BITS-1:0] cnt;

    // Two-flop synchroniser; resets to the idle (high) level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make sync_2 take the old sync_1,
            // giving two real flop stages regardless of statement order.
            sync_1 <= pin;
            sync_2 <= sync_1;
        end
    end

    // Saturating counter steps toward the synchronised level on each tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= CNT_MAX;
        end else if (tick) begin
            if (sync_2 && (cnt != CNT_MAX)) begin
                cnt <= cnt + 1'b1;
            end else if (!sync_2 && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Filtered line switches only at the counter extremes, holds in between
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line <= 1'b1;
        end else if (cnt == CNT_MAX) begin
            line <= 1'b1;
        end else if (cnt == '0) begin
            line <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver. Oversamples the filtered RX line, samples each
// bit at mid-bit, and presents each word on a valid/ready output register
// with parity, framing and sticky overrun flags.
// Optional build macro UART_RX_BREAK_DET_EN: an all-zero frame is reported
// as a one-cycle rx_break pulse instead of being committed as a word.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_DIV      = 27,
    parameter int OVERSAMPLING = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FILTER_BITS  = 3,
    parameter int STARTUP_WAIT = 2000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_pin,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun,
    output logic                 rx_break
);

    localparam int DIV_W  = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;
    localparam int PH_W   = clog2(OVERSAMPLING);
    localparam int BIT_W  = clog2(DATA_BITS + 1);
    localparam int INIT_W = (STARTUP_WAIT > 1) ? clog2(STARTUP_WAIT) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0]   PH_MID    = PH_W'(OVERSAMPLING / 2 - 1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(OVERSAMPLING - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(STARTUP_WAIT - 1);

    rx_state_t            state;
    rx_state_t            state_next;
    logic [DIV_W-1:0]     div_cnt;
    logic [INIT_W-1:0]    init_cnt;
    logic [PH_W-1:0]      phase;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_err;
    logic                 frame_err;
    logic                 tick;
    logic                 line;
    logic                 sample;
    logic                 init_done;
    logic                 commit;
    logic                 brk_det;

    uart_rx_filter #(
        .FILTER_BITS(FILTER_BITS)
    ) u_filter (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick),
        .pin  (rx_pin),
        .line (line)
    );

    assign tick      = (div_cnt == DIV_LAST);
    assign sample    = tick && (phase == PH_LAST);
    assign init_done = (init_cnt == INIT_LAST);

    // Oversample tick divider, wraps at CLK_DIV-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Start-up hold-off counter, only runs while waiting after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt <= '0;
        end else if ((state == ST_WAIT_INIT) && !init_done) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    logic all_zero;
    logic brk_q;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT_INIT;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state plus commit / break strobes for the last stop sample
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch
        // is inferred on paths that do not assign it.
        state_next = state;
        commit     = 1'b0;
        brk_det    = 1'b0;
        case (state)
            ST_WAIT_INIT: begin
                if (init_done) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (tick && !line) state_next = ST_START;
            end
            ST_START: begin
                if (tick && (phase == PH_MID)) begin
                    state_next = line ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (sample && (bit_cnt == DATA_LAST)) begin
                    state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (sample) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (sample && (bit_cnt == STOP_LAST)) begin
`ifdef UART_RX_BREAK_DET_EN
                    if (all_zero && !line) begin
                        brk_det = 1'b1;
                    end else begin
                        commit = 1'b1;
                    end
`else
                    commit = 1'b1;
`endif
                    // A low final stop sample must see the line go idle first
                    state_next = line ? ST_IDLE : ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (tick && line) state_next = ST_IDLE;
            end
            default: state_next = ST_WAIT_INIT;
        endcase
    end

    // Frame datapath: phase counter, bit counter, shift register, error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            all_zero  <= 1'b0;
`endif
        end else if (tick) begin
            case (state)
                ST_IDLE: begin
                    phase <= '0;
                end
                ST_START: begin
                    if (phase == PH_MID) begin
                        phase     <= '0;
                        bit_cnt   <= '0;
                        par_err   <= 1'b0;
                        frame_err <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
                        all_zero  <= 1'b1;
`endif
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                ST_DATA, ST_PARITY, ST_STOP: begin
                    if (phase == PH_LAST) begin
                        phase <= '0;
`ifdef UART_RX_BREAK_DET_EN
                        all_zero <= all_zero & ~line;
`endif
                        if (state == ST_DATA) begin
                            // LSB arrives first, so shift right into the MSB
                            shift_reg <= {line, shift_reg[DATA_BITS-1:1]};
                            bit_cnt   <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 1'b1;
                        end else if (state == ST_PARITY) begin
                            par_err <= (PARITY == PAR_ODD) ? ~(^shift_reg ^ line)
                                                           :  (^shift_reg ^ line);
                        end else begin
                            frame_err <= frame_err | ~line;
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: begin
                    phase <= '0;
                end
            endcase
        end
    end

    // Output word register with valid/ready handshake and sticky overrun
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_overrun    <= 1'b0;
        end else begin
            if (commit && (!rx_valid || rx_ready)) begin
                rx_data       <= shift_reg;
                rx_parity_err <= par_err;
                rx_frame_err  <= frame_err | ~line;
                rx_valid      <= 1'b1;
            end else begin
                if (commit) begin
                    rx_overrun <= 1'b1;
                end
                if (rx_valid && rx_ready) begin
                    rx_valid <= 1'b0;
                end
            end
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    // One-cycle break pulse, aligned with where a commit would have landed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            brk_q <= 1'b0;
        end else begin
            brk_q <= brk_det;
        end
    end
    assign rx_break = brk_q;
`else
    assign rx_break = 1'b0;
`endif

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised UART receiver and the successor to the fixed 8N1 receiver.
- Synchronises and glitch-filters the RX pin, oversamples it, and samples each bit at mid-bit.
- Data width, parity, stop-bit count, oversampling ratio and baud divider are all configurable.
- Holds each received word in an output register with a valid/ready handshake and per-word error flags.
- Sits between the board RX pin and the command/FIFO logic.

Parameters:
- CLK_DIV, 27: CLK cycles per oversample tick (50 MHz / 27 = 16 x 115740 Hz).
- OVERSAMPLING, 16: oversample ticks per bit. Must be a power of two, 8 to 32.
- DATA_BITS, 8: data bits per frame, 5 to 9, LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FILTER_BITS, 3: width of the saturating glitch-filter counter.
- STARTUP_WAIT, 2000000: CLK cycles after reset during which RX is ignored.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- RX_PIN  in  1  serial input, asynchronous, idles high.
- RX_DATA  out  DATA_BITS  received word.
- RX_VALID  out  1  RX_DATA and the error flags are valid.
- RX_READY  in  1  consumer accepts the word.
- RX_PARITY_ERR  out  1  parity mismatch on this word.
- RX_FRAME_ERR  out  1  a stop bit was sampled low.
- RX_OVERRUN  out  1  sticky; a word was lost.
- RX_BREAK  out  1  break-detect pulse (see Optional Feature).

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous, active-low.
  - Reset values: all outputs 0, RX_DATA 0.
  - Internal state after reset: filter counter saturated high, filtered line = 1, FSM in WAIT_INIT.
- Input path:
  - RX_PIN passes through a 2-flop synchroniser.
  - The tick counter counts 0..CLK_DIV-1 and produces a one-CLK tick at wrap.
  - On each tick, the filter counter steps toward the synchronised level and saturates.
  - The filtered line becomes 1 at counter all-ones and 0 at zero; otherwise it holds.
- FSM (all transitions on ticks except WAIT_INIT):
  - WAIT_INIT: counts STARTUP_WAIT CLK cycles, then goes to IDLE.
  - IDLE: on filtered line = 0, goes to START and clears the phase counter.
  - START: at phase OVERSAMPLING/2-1 (mid start bit):
    - line 0: go to DATA and clear the phase counter;
    - line 1: false start, return to IDLE.
  - DATA: samples at phase OVERSAMPLING-1, shifting right into the MSB. After DATA_BITS samples, go to PARITY if PARITY != 0, else STOP.
  - PARITY: one sample. Error when XOR(data, sample) = 0 for odd, or = 1 for even.
  - STOP: STOP_BITS samples. Any 0 sets the frame error. After the last stop sample, commit and go to IDLE.
  - A frame-error commit returns to IDLE only once the filtered line is 1.
- Commit (one CLK, on the last stop sample tick):
  - If RX_VALID = 0 or RX_READY = 1 in that cycle: load RX_DATA, RX_PARITY_ERR and RX_FRAME_ERR; set RX_VALID.
  - Otherwise: keep the old word, set RX_OVERRUN.
- Handshake:
  - RX_VALID clears on the cycle after RX_VALID & RX_READY, unless a commit occurs in that same cycle; then it stays 1 with the new word.
  - Outputs are stable while RX_VALID = 1 and RX_READY = 0.
- RX_OVERRUN clears only on reset.
- Latency: RX_VALID rises 1 CLK after the final stop-bit sample tick.
- Asserting RST_N low mid-frame aborts the frame; no word is produced.

Optional Feature:
- Macro: UART_RX_BREAK_DET_EN.
- Defined:
  - A frame whose start, data, parity and stop samples are all 0 is not committed.
  - RX_BREAK pulses for 1 CLK at the stop sample.
  - The FSM enters BREAK and waits for filtered line = 1 before IDLE.
- Undefined:
  - Such a frame commits as data 0 with RX_FRAME_ERR = 1.
  - RX_BREAK is tied to 0.

Decomposition:
- Package uart_pkg:
  - parity encodings PAR_NONE / PAR_ODD / PAR_EVEN;
  - FSM state enum (WAIT_INIT, IDLE, START, DATA, PARITY, STOP, BREAK);
  - clog2 helper.
- Sub-module uart_rx_filter: synchroniser plus saturating filter, driven by the tick input. It will be shared with a future uart_tx loopback checker.

Test Plan:
All scenarios use CLK_DIV=2, OVERSAMPLING=16 and STARTUP_WAIT=16 unless stated.
- 8N1, send 0xA5, RX_READY=1 -> one RX_VALID with RX_DATA=0xA5, no error flags.
- PARITY=2, send 0x3C with parity 1 -> RX_DATA=0x3C, RX_PARITY_ERR=1. Send it again with parity 0 -> RX_PARITY_ERR=0.
- Stop bit driven low on 0x55 -> RX_FRAME_ERR=1, RX_DATA=0x55. No new frame is started until the line returns high.
- RX_READY=0, send 0x11 then 0x22 -> RX_DATA stays 0x11, RX_OVERRUN=1. Raising RX_READY drops RX_VALID next cycle.
- 3-tick low glitch in IDLE, and a low pulse of half a bit -> no RX_VALID (filter and false-start rejection). Frame sent during WAIT_INIT -> ignored.
- With UART_RX_BREAK_DET_EN, line held low for 12 bit times -> one RX_BREAK pulse, no RX_VALID. Receipt of 0x0F afterwards is normal.
